// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package data_mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;
endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU load/store request bus plus backing-memory port of the data-memory controller.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              done;
  logic              err;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, mem_rdata,
    output rdata, stall, done, err, mem_en, mem_wr, mem_addr, mem_wdata
  );
  modport master (
    output req_rd, req_wr, req_addr, req_wdata, mem_rdata,
    input  rdata, stall, done, err, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_ctrl_latency_counter.sv
// Down-counter timing the BUSY phase; is_last marks the cycle memory data is valid.
module latency_counter
  import data_mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_last_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                        cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign is_last_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller: stalls the CPU across a fixed-latency access.
// Optional misaligned-address trap enabled by DATA_MEM_ALIGN_CHECK_EN.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  data_mem_ctrl_if.slave  bus
);
  state_e            state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              req, misalign, cnt_load, cnt_last;

  assign req = bus.req_rd | bus.req_wr;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic err_q;
  assign misalign = bus.req_addr[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state_q == IDLE) && req && misalign;
  assign bus.err = err_q;
`else
  assign misalign = 1'b0;
  assign bus.err  = 1'b0;
`endif

  latency_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(LATENCY)),
    .dec_i      (state_q == BUSY),
    .is_last_o  (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    cnt_load    = 1'b0;
    unique case (state_q)
      IDLE: if (req) begin
        if (misalign) state_d = DONE;
        else begin
          // write has priority when both request lines are up
          state_d     = BUSY;
          mem_en_d    = 1'b1;
          mem_wr_d    = bus.req_wr;
          mem_addr_d  = bus.req_addr;
          mem_wdata_d = bus.req_wdata;
          cnt_load    = 1'b1;
        end
      end
      BUSY: if (cnt_last) begin
        state_d = DONE;
        if (!mem_wr_q) rdata_d = bus.mem_rdata;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end

  // gated by rst_n so a request held through reset does not freeze the core
  assign bus.stall     = rst_n & (((state_q == IDLE) & req) | (state_q == BUSY));
  assign bus.done      = (state_q == DONE);
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl with a timeline-based reference model.
module tb_data_mem_ctrl;
  localparam int LAT = 4;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus();
  data_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // backing memory: responds only in the cycle LAT-1 after issue, noise otherwise
  logic [15:0] bmem [logic [15:0]];
  int bcyc = 0, p_at = 0;
  bit pend = 0;
  logic [15:0] p_addr;
  always @(negedge clk) begin
    bcyc++;
    if (!rst_n) pend = 0;
    else if (bus.mem_en) begin
      if (bus.mem_wr) bmem[bus.mem_addr] = bus.mem_wdata;
      else begin pend = 1; p_addr = bus.mem_addr; p_at = bcyc + LAT - 1; end
    end
    if (pend && bcyc == p_at) begin
      bus.mem_rdata = bmem.exists(p_addr) ? bmem[p_addr] : init_val(p_addr);
      pend = 0;
    end else bus.mem_rdata = 16'($urandom);
  end

  // reference model: an accepted access defines its whole timeline from its start cycle
  logic [15:0] rmem [logic [15:0]];
  int mcyc = 0, m_t0 = 0, k;
  bit m_act = 0, m_wr, m_mis;
  logic [15:0] m_addr, m_wd, m_rdata = 0, m_maddr = 0, m_mwd = 0;
  bit e_st, e_en, e_dn, e_err;
  always @(negedge clk) begin
    mcyc++;
    e_st = 0; e_en = 0; e_dn = 0; e_err = 0;
    if (!rst_n) begin
      m_act = 0; m_rdata = 0; m_maddr = 0; m_mwd = 0;
    end else begin
      if (!m_act && (bus.req_rd || bus.req_wr)) begin
        m_act = 1; m_t0 = mcyc; m_wr = bus.req_wr;
        m_addr = bus.req_addr; m_wd = bus.req_wdata;
        m_mis = ALIGN && bus.req_addr[0];
        if (m_wr && !m_mis) rmem[m_addr] = m_wd;
      end
      k = mcyc - m_t0;
      if (m_act && m_mis) begin
        e_st = (k == 0); e_dn = (k == 1); e_err = (k == 1);
      end else if (m_act) begin
        e_st = (k <= LAT); e_en = (k == 1); e_dn = (k == LAT + 1);
        if (k == 1) begin m_maddr = m_addr; m_mwd = m_wd; end
        if (k == LAT + 1 && !m_wr)
          m_rdata = rmem.exists(m_addr) ? rmem[m_addr] : init_val(m_addr);
      end
    end
    chk("stall", bus.stall, e_st);
    chk("mem_en", bus.mem_en, e_en);
    chk("done", bus.done, e_dn);
    chk("err", bus.err, e_err);
    chk("rdata", bus.rdata, m_rdata);
    chk("mem_addr", bus.mem_addr, m_maddr);
    chk("mem_wdata", bus.mem_wdata, m_mwd);
    if (e_en) chk("mem_wr", bus.mem_wr, m_wr);
    if (m_act && e_dn) m_act = 0;
  end

  // per-access trace, index 0 = request cycle
  logic [31:0] tr_st, tr_en, tr_dn, tr_er;
  logic [15:0] tr_wd;
  logic        tr_mw;

  // entered at posedge+1; leaves at posedge+1 of the cycle after done with requests dropped
  task automatic run_access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    int n;
    bus.req_rd = rd; bus.req_wr = wr; bus.req_addr = a; bus.req_wdata = d;
    tr_st = 0; tr_en = 0; tr_dn = 0; tr_er = 0; tr_wd = 0; tr_mw = 0;
    n = 0;
    do begin
      @(negedge clk);
      tr_st[n] = bus.stall; tr_en[n] = bus.mem_en;
      tr_dn[n] = bus.done;  tr_er[n] = bus.err;
      if (n == 1) begin tr_wd = bus.mem_wdata; tr_mw = bus.mem_wr; end
      n++;
    end while (!bus.done && n < 30);
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_rd = 0; bus.req_wr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn_cnt;
    bus.req_rd = 0; bus.req_wr = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bmem[16'h0010] = 16'hBEEF;
    rmem[16'h0010] = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_stall", bus.stall, 0);
    chk("idle_rdata", bus.rdata, 0);
    chk("idle_mem_en", bus.mem_en, 0);

    run_access(1, 0, 16'h0010, 16'h0000);
    chk("rd_stall_tr", tr_st[5:0], 6'b011111);
    chk("rd_en_tr", tr_en[5:0], 6'b000010);
    chk("rd_done_tr", tr_dn[5:0], 6'b100000);
    chk("rd_rdata", bus.rdata, 16'hBEEF);

    run_access(0, 1, 16'h0022, 16'h1234);
    chk("wr_en_tr", tr_en[5:0], 6'b000010);
    chk("wr_mem_wr", tr_mw, 1);
    chk("wr_wdata", tr_wd, 16'h1234);
    chk("wr_done_tr", tr_dn[5:0], 6'b100000);
    chk("wr_rdata_kept", bus.rdata, 16'hBEEF);

    run_access(1, 1, 16'h0030, 16'h5555);
    chk("both_is_write", tr_mw, 1);
    run_access(1, 0, 16'h0030, 16'h0000);
    chk("b2b_stall_tr", tr_st[5:0], 6'b011111);
    chk("b2b_rdata", bus.rdata, 16'h5555);

    run_access(1, 0, 16'h0011, 16'h0000);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    chk("mis_stall_tr", tr_st[1:0], 2'b01);
    chk("mis_en_tr", tr_en[1:0], 2'b00);
    chk("mis_done_tr", tr_dn[1:0], 2'b10);
    chk("mis_err_tr", tr_er[1:0], 2'b10);
    chk("mis_rdata_kept", bus.rdata, 16'h5555);
`else
    chk("odd_en_tr", tr_en[5:0], 6'b000010);
    chk("odd_err_tr", tr_er[5:0], 6'b000000);
    chk("odd_rdata", bus.rdata, 16'hC3B4);
`endif

    // reset in the middle of a read
    bus.req_rd = 1; bus.req_addr = 16'h0020;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rdata", bus.rdata, 0);
    bus.req_rd = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    dn_cnt = 0;
    repeat (8) begin @(negedge clk); if (bus.done) dn_cnt++; end
    chk("no_done_after_rst", dn_cnt, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 80; i++) begin
      int gap;
      bit rd, wr;
      wr = $urandom_range(0, 2) == 0;
      rd = !wr || ($urandom_range(0, 3) == 0);
      run_access(rd, wr, 16'($urandom_range(0, 15)), 16'($urandom));
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
